// File: rtl/graph_mem_pkg.sv
// Shared types and default sizes for the graph memory request protocol
// (used by graph_mem_server and graph_fetch).
package graph_mem_pkg;

  localparam int GM_ADDR_WIDTH = 12;
  localparam int GM_DEPTH      = 4096;

  typedef logic [31:0] word_t;

  typedef enum logic {
    CH_A = 1'b0,
    CH_B = 1'b1
  } chan_e;

  // One entry per issued read, travelling alongside the BRAM output.
  typedef struct packed {
    logic  valid;
    chan_e chan;
    logic  in_range;
  } rd_tag_t;

  function automatic chan_e other_chan(input chan_e c);
    return (c == CH_A) ? CH_B : CH_A;
  endfunction

endpackage

// File: rtl/gms_req_fifo.sv
// Per-channel request FIFO for graph_mem_server: single-clock ring buffer.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module gms_req_fifo
  import graph_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic [31:0]            i_data,
  input  logic                   i_pop,
  output logic [31:0]            o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int          PW       = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  word_t         r_mem [DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [PW:0]   r_count;
  logic          w_doPop;
  logic          w_doPush;

  assign o_full   = (r_count == FULL_CNT);
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_data   = r_mem[r_rdPtr];
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_data;
  end

endmodule

// File: rtl/graph_mem_server.sv
// Two-channel graph memory responder: per-channel request FIFOs, round-robin read issue,
// loader writes with priority. GRAPH_MEM_STATS_EN adds saturating read/write counters.
module graph_mem_server
  import graph_mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = GM_ADDR_WIDTH,
  parameter int DEPTH        = GM_DEPTH,
  parameter int FIFO_DEPTH   = 4,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] req_addr_a,
  input  logic        req_valid_a,
  output logic [31:0] resp_data_a,
  output logic        resp_valid_a,
  input  logic [31:0] req_addr_b,
  input  logic        req_valid_b,
  output logic [31:0] resp_data_b,
  output logic        resp_valid_b,
  input  logic [31:0] wr_addr_in,
  input  logic [31:0] wr_data_in,
  input  logic        wr_valid_in,
  output logic        full_a_out,
  output logic        full_b_out,
  output logic        overflow_out,
  output logic        range_err_out
`ifdef GRAPH_MEM_STATS_EN
  ,
  output logic [31:0] rd_count_a_out,
  output logic [31:0] rd_count_b_out,
  output logic [31:0] wr_count_out
`endif
);

  localparam int               FIFO_PW       = $clog2(FIFO_DEPTH);
  localparam logic [FIFO_PW:0] FIFO_FULL_CNT = (FIFO_PW + 1)'(FIFO_DEPTH);

  word_t            w_headA, w_headB;
  logic             w_fullA, w_fullB, w_emptyA, w_emptyB;
  logic [FIFO_PW:0] w_countA, w_countB;
  logic             w_popA, w_popB;
  logic             w_grantValid;
  chan_e            w_grantChan;
  chan_e            r_rrPtr;
  word_t            w_rdAddr;
  logic             w_rdInRange, w_wrInRange;
  logic             w_dropA, w_dropB;
  rd_tag_t          w_issueTag, w_exitTag;
  word_t            w_exitData;
  rd_tag_t          r_tagPipe [READ_LATENCY];
  word_t            r_dataPipe [READ_LATENCY];
  word_t            r_mem [DEPTH];
  word_t            r_holdA, r_holdB;
  logic             r_overflow, r_rangeErr;

  gms_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifoA (
    .i_clk(clk_in), .i_rst(rst_in), .i_push(req_valid_a), .i_data(req_addr_a),
    .i_pop(w_popA), .o_data(w_headA), .o_full(w_fullA), .o_empty(w_emptyA), .o_count(w_countA)
  );

  gms_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifoB (
    .i_clk(clk_in), .i_rst(rst_in), .i_push(req_valid_b), .i_data(req_addr_b),
    .i_pop(w_popB), .o_data(w_headB), .o_full(w_fullB), .o_empty(w_emptyB), .o_count(w_countB)
  );

  // A loader write owns the BRAM port for its cycle; otherwise pick a read round-robin.
  always_comb begin
    w_grantValid = 1'b0;
    w_grantChan  = CH_A;
    if (!wr_valid_in) begin
      if (!w_emptyA && !w_emptyB) begin
        w_grantValid = 1'b1;
        w_grantChan  = r_rrPtr;
      end else if (!w_emptyA) begin
        w_grantValid = 1'b1;
        w_grantChan  = CH_A;
      end else if (!w_emptyB) begin
        w_grantValid = 1'b1;
        w_grantChan  = CH_B;
      end
    end
  end

  assign w_popA      = w_grantValid && (w_grantChan == CH_A);
  assign w_popB      = w_grantValid && (w_grantChan == CH_B);
  assign w_rdAddr    = (w_grantChan == CH_A) ? w_headA : w_headB;
  assign w_rdInRange = (w_rdAddr < 32'(DEPTH));
  assign w_wrInRange = (wr_addr_in < 32'(DEPTH));
  assign w_dropA     = req_valid_a && w_fullA && !w_popA;
  assign w_dropB     = req_valid_b && w_fullB && !w_popB;
  assign w_issueTag  = '{valid: w_grantValid, chan: w_grantChan, in_range: w_rdInRange};

  // BRAM port plus the data side of the read pipeline; contents survive reset.
  always_ff @(posedge clk_in) begin
    if (wr_valid_in && w_wrInRange && !rst_in) r_mem[wr_addr_in[ADDR_WIDTH-1:0]] <= wr_data_in;
    r_dataPipe[0] <= r_mem[w_rdAddr[ADDR_WIDTH-1:0]];
    for (int i = 1; i < READ_LATENCY; i++) r_dataPipe[i] <= r_dataPipe[i-1];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < READ_LATENCY; i++) r_tagPipe[i] <= '0;
      r_rrPtr    <= CH_A;
      r_holdA    <= '0;
      r_holdB    <= '0;
      r_overflow <= 1'b0;
      r_rangeErr <= 1'b0;
    end else begin
      r_tagPipe[0] <= w_issueTag;
      for (int i = 1; i < READ_LATENCY; i++) r_tagPipe[i] <= r_tagPipe[i-1];
      if (w_grantValid) r_rrPtr <= other_chan(w_grantChan);
      r_holdA    <= resp_data_a;
      r_holdB    <= resp_data_b;
      r_overflow <= r_overflow || w_dropA || w_dropB;
      r_rangeErr <= r_rangeErr || (w_grantValid && !w_rdInRange) || (wr_valid_in && !w_wrInRange);
    end
  end

  assign w_exitTag     = r_tagPipe[READ_LATENCY-1];
  assign w_exitData    = w_exitTag.in_range ? r_dataPipe[READ_LATENCY-1] : '0;
  assign resp_valid_a  = w_exitTag.valid && (w_exitTag.chan == CH_A);
  assign resp_valid_b  = w_exitTag.valid && (w_exitTag.chan == CH_B);
  assign resp_data_a   = resp_valid_a ? w_exitData : r_holdA;
  assign resp_data_b   = resp_valid_b ? w_exitData : r_holdB;
  assign full_a_out    = (w_countA == FIFO_FULL_CNT);
  assign full_b_out    = (w_countB == FIFO_FULL_CNT);
  assign overflow_out  = r_overflow;
  assign range_err_out = r_rangeErr;

`ifdef GRAPH_MEM_STATS_EN
  logic [31:0] r_rdCntA, r_rdCntB, r_wrCnt;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_rdCntA <= '0;
      r_rdCntB <= '0;
      r_wrCnt  <= '0;
    end else begin
      if (w_popA && (r_rdCntA != '1)) r_rdCntA <= r_rdCntA + 1'b1;
      if (w_popB && (r_rdCntB != '1)) r_rdCntB <= r_rdCntB + 1'b1;
      if (wr_valid_in && w_wrInRange && (r_wrCnt != '1)) r_wrCnt <= r_wrCnt + 1'b1;
    end
  end

  assign rd_count_a_out = r_rdCntA;
  assign rd_count_b_out = r_rdCntB;
  assign wr_count_out   = r_wrCnt;
`endif

endmodule

// File: tb/tb_graph_mem_server.sv
// Self-checking bench for graph_mem_server: directed vector tables, hand sequences for
// overflow and mid-flight reset, then random traffic against a queue-based reference model.
module tb_graph_mem_server;
  import graph_mem_pkg::*;

  localparam int RL    = 2;
  localparam int FD    = 4;
  localparam int AW    = GM_ADDR_WIDTH;
  localparam int DEPTH = GM_DEPTH;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] req_addr_a, req_addr_b, wr_addr_in, wr_data_in;
  logic        req_valid_a, req_valid_b, wr_valid_in;
  logic [31:0] resp_data_a, resp_data_b;
  logic        resp_valid_a, resp_valid_b;
  logic        full_a_out, full_b_out, overflow_out, range_err_out;
`ifdef GRAPH_MEM_STATS_EN
  logic [31:0] rd_count_a_out, rd_count_b_out, wr_count_out;
`endif

  always #5 clk_in = ~clk_in;

  graph_mem_server #(
    .ADDR_WIDTH(AW), .DEPTH(DEPTH), .FIFO_DEPTH(FD), .READ_LATENCY(RL)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req_addr_a(req_addr_a), .req_valid_a(req_valid_a),
    .resp_data_a(resp_data_a), .resp_valid_a(resp_valid_a),
    .req_addr_b(req_addr_b), .req_valid_b(req_valid_b),
    .resp_data_b(resp_data_b), .resp_valid_b(resp_valid_b),
    .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in), .wr_valid_in(wr_valid_in),
    .full_a_out(full_a_out), .full_b_out(full_b_out),
    .overflow_out(overflow_out), .range_err_out(range_err_out)
`ifdef GRAPH_MEM_STATS_EN
    ,
    .rd_count_a_out(rd_count_a_out), .rd_count_b_out(rd_count_b_out),
    .wr_count_out(wr_count_out)
`endif
  );

  int nChecks = 0;
  int nFail   = 0;

  typedef struct {
    bit rs; bit vA; logic [31:0] aA; bit vB; logic [31:0] aB;
    bit wv; logic [31:0] wa; logic [31:0] wd;
    bit chk; bit xVA; logic [31:0] xDA; bit xVB; logic [31:0] xDB;
  } vec_t;

  function automatic vec_t mkVec(bit rs, bit vA, logic [31:0] aA, bit vB, logic [31:0] aB,
                                 bit wv, logic [31:0] wa, logic [31:0] wd,
                                 bit chk, bit xVA, logic [31:0] xDA, bit xVB, logic [31:0] xDB);
    vec_t v;
    v.rs = rs; v.vA = vA; v.aA = aA; v.vB = vB; v.aB = aB;
    v.wv = wv; v.wa = wa; v.wd = wd;
    v.chk = chk; v.xVA = xVA; v.xDA = xDA; v.xVB = xVB; v.xDB = xDB;
    return v;
  endfunction

  function automatic logic [31:0] preVal(int i);
    case (i)
      10:      return 32'hA0;
      11:      return 32'hB0;
      12:      return 32'hC0;
      default: return 32'h100 + 32'(i);
    endcase
  endfunction

  // Reference model: word array, per-channel request queues, list of scheduled responses.
  typedef struct { int due; bit chB; logic [31:0] data; } pend_t;
  logic [31:0] mMem [DEPTH];
  logic [31:0] qA[$], qB[$];
  pend_t       pend[$];
  bit          mNextB = 1'b0;
  int          cyc    = 0;
  bit          eVA = 0, eVB = 0, eOvf = 0, eRng = 0, eFA = 0, eFB = 0;
  logic [31:0] eDA = '0, eDB = '0;
  logic [31:0] gotA[$], gotB[$];
  int          gotACyc[$];

  task automatic modelStep();
    logic [31:0] a;
    bit takeB;
    pend_t p;
    if (rst_in) begin
      qA.delete(); qB.delete(); pend.delete();
      mNextB = 1'b0; eOvf = 1'b0; eRng = 1'b0; eDA = '0; eDB = '0;
    end else begin
      if (wr_valid_in) begin
        if (wr_addr_in < 32'(DEPTH)) mMem[wr_addr_in[AW-1:0]] = wr_data_in;
        else eRng = 1'b1;
      end else if (qA.size() != 0 || qB.size() != 0) begin
        takeB = (qA.size() == 0) || (qB.size() != 0 && mNextB);
        if (takeB) a = qB.pop_front(); else a = qA.pop_front();
        mNextB = !takeB;
        if (a >= 32'(DEPTH)) eRng = 1'b1;
        p.due  = cyc + RL;
        p.chB  = takeB;
        p.data = (a < 32'(DEPTH)) ? mMem[a[AW-1:0]] : 32'h0;
        pend.push_back(p);
      end
      if (req_valid_a) begin
        if (qA.size() >= FD) eOvf = 1'b1; else qA.push_back(req_addr_a);
      end
      if (req_valid_b) begin
        if (qB.size() >= FD) eOvf = 1'b1; else qB.push_back(req_addr_b);
      end
    end
    cyc++;
    eVA = 1'b0;
    eVB = 1'b0;
    while (pend.size() != 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      if (p.chB) begin eVB = 1'b1; eDB = p.data; end
      else begin eVA = 1'b1; eDA = p.data; end
    end
    eFA = (qA.size() == FD);
    eFB = (qB.size() == FD);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("[TB] FAIL %s at cycle %0d: got %h, required %h", name, cyc, got, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst_in      = v.rs;
    req_valid_a = v.vA; req_addr_a = v.aA;
    req_valid_b = v.vB; req_addr_b = v.aB;
    wr_valid_in = v.wv; wr_addr_in = v.wa; wr_data_in = v.wd;
  endtask

  task automatic modelCheck();
    checkOutput("modelValidA", 32'(resp_valid_a), 32'(eVA));
    checkOutput("modelDataA", resp_data_a, eDA);
    checkOutput("modelValidB", 32'(resp_valid_b), 32'(eVB));
    checkOutput("modelDataB", resp_data_b, eDB);
    checkOutput("modelFullA", 32'(full_a_out), 32'(eFA));
    checkOutput("modelFullB", 32'(full_b_out), 32'(eFB));
    checkOutput("modelOverflow", 32'(overflow_out), 32'(eOvf));
    checkOutput("modelRangeErr", 32'(range_err_out), 32'(eRng));
  endtask

  // One clock: drive inputs, check this cycle's outputs at the falling edge, advance the model.
  task automatic runVec(input vec_t v);
    applyStimulus(v);
    @(negedge clk_in);
    modelCheck();
    if (v.chk) begin
      checkOutput("tblValidA", 32'(resp_valid_a), 32'(v.xVA));
      checkOutput("tblDataA", resp_data_a, v.xDA);
      checkOutput("tblValidB", 32'(resp_valid_b), 32'(v.xVB));
      checkOutput("tblDataB", resp_data_b, v.xDB);
    end
    if (resp_valid_a) begin gotA.push_back(resp_data_a); gotACyc.push_back(cyc); end
    if (resp_valid_b) gotB.push_back(resp_data_b);
    @(posedge clk_in);
    modelStep();
    #1;
  endtask

  function automatic logic [31:0] randAddr();
    if ($urandom_range(0, 19) == 0) return 32'(DEPTH) + 32'($urandom_range(0, 3000));
    return 32'($urandom_range(0, 31));
  endfunction

  initial begin
    vec_t tbl[$];
    vec_t idle;
    vec_t rstRow;
    vec_t v;
    int   t0;
    bit   found;

    foreach (mMem[i]) mMem[i] = '0;
    idle   = mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rstRow = mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Test 1: single A request to word 10.
    tbl.push_back(rstRow);
    tbl.push_back(mkVec(0, 1, 10, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hA0, 0, 0));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hA0, 0, 0));
    // Test 2: simultaneous A/B requests, then a second burst alternating again.
    tbl.push_back(rstRow);
    tbl.push_back(mkVec(0, 1, 11, 1, 12, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hB0, 0, 0));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hB0, 1, 32'hC0));
    tbl.push_back(mkVec(0, 1, 10, 1, 11, 0, 0, 0, 1, 0, 32'hB0, 0, 32'hC0));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hB0, 0, 32'hC0));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hB0, 0, 32'hC0));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hA0, 0, 32'hC0));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hA0, 1, 32'hB0));
    // Test 3: write word 20, read it back on B the next cycle.
    tbl.push_back(rstRow);
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 1, 20, 32'h1234, 1, 0, 0, 0, 0));
    tbl.push_back(mkVec(0, 0, 0, 1, 20, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h1234));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h1234));
    // Test 4: out-of-range read returns zero even though word 904 aliases the address bits.
    tbl.push_back(rstRow);
    tbl.push_back(mkVec(0, 1, 5000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));

    applyStimulus(rstRow);
    repeat (2) begin
      @(posedge clk_in);
      modelStep();
    end
    #1;
    applyStimulus(idle);
    checkOutput("rstValidA", 32'(resp_valid_a), 0);
    checkOutput("rstDataA", resp_data_a, 0);
    checkOutput("rstValidB", 32'(resp_valid_b), 0);
    checkOutput("rstDataB", resp_data_b, 0);
    checkOutput("rstFlags", {28'h0, full_a_out, full_b_out, overflow_out, range_err_out}, 0);

    $display("[TB] preloading words 0..31 and 904");
    for (int i = 0; i < 32; i++) runVec(mkVec(0, 0, 0, 0, 0, 1, i, preVal(i), 0, 0, 0, 0, 0));
    runVec(mkVec(0, 0, 0, 0, 0, 1, 904, 32'hDEAD, 0, 0, 0, 0, 0));

    $display("[TB] directed vector tables");
    foreach (tbl[i]) runVec(tbl[i]);
    checkOutput("rangeErrSticky", 32'(range_err_out), 1);

    $display("[TB] overflow sequence");
    runVec(rstRow);
    gotA.delete();
    for (int i = 0; i < 6; i++) begin
      v = mkVec(0, 1, i, 0, 0, (i >= 2), 100 + i, 32'hF00 + i, 0, 0, 0, 0, 0);
      runVec(v);
    end
    checkOutput("ovfSet", 32'(overflow_out), 1);
    checkOutput("ovfFullA", 32'(full_a_out), 1);
    for (int i = 0; i < 15; i++) runVec(idle);
    checkOutput("ovfRespCount", 32'(gotA.size()), 5);
    for (int k = 0; k < 5 && k < gotA.size(); k++) checkOutput("ovfRespOrder", gotA[k], preVal(k));

    $display("[TB] reset with reads in flight");
    runVec(rstRow);
    gotA.delete(); gotB.delete(); gotACyc.delete();
    runVec(mkVec(0, 1, 10, 1, 11, 0, 0, 0, 0, 0, 0, 0, 0));
    runVec(idle);
    runVec(rstRow);
    for (int i = 0; i < 5; i++) runVec(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    checkOutput("rstNoRespA", 32'(gotA.size()), 0);
    checkOutput("rstNoRespB", 32'(gotB.size()), 0);
    t0 = cyc;
    runVec(mkVec(0, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      runVec(idle);
      found = (gotA.size() != 0);
    end
    checkOutput("rstFreshTimeout", 32'(found), 1);
    if (found) begin
      checkOutput("rstFreshData", gotA[0], 32'hA0);
      checkOutput("rstFreshLatency", 32'(gotACyc[0] - t0), 32'(RL + 1));
    end

    $display("[TB] random traffic against the reference model");
    for (int n = 0; n < 800; n++) begin
      v    = idle;
      v.rs = ($urandom_range(0, 99) == 0);
      v.wv = ($urandom_range(0, 7) == 0);
      v.wa = ($urandom_range(0, 15) == 0) ? 32'(DEPTH) + 32'($urandom_range(0, 100))
                                          : 32'($urandom_range(0, 31));
      v.wd = $urandom();
      v.vA = ($urandom_range(0, 99) < 45);
      v.aA = randAddr();
      v.vB = ($urandom_range(0, 99) < 45);
      v.aB = randAddr();
      runVec(v);
    end
    for (int i = 0; i < 12; i++) runVec(idle);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
